// File: rtl/nested_loop_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : nested_loop_sched                                                 |
// | Desc   : Two-level nested-loop sequencer issuing one valid/ready action per |
// |          inner iteration, with index tracking, action count, busy/done.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module nested_loop_sched #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   outer_n,
    input  logic [W-1:0]   inner_n,
    input  logic           abort,
    output logic           act_valid,
    input  logic           act_ready,
    output logic [W-1:0]   x_idx,
    output logic [W-1:0]   y_idx,
    output logic [2*W-1:0] act_cnt,
    output logic           busy,
    output logic           done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [W-1:0]   IDX_ONE = W'(1);
    localparam logic [2*W-1:0] CNT_ONE = (2*W)'(1);

    state_t         state_q, state_d;
    logic [W-1:0]   outer_q, outer_d;
    logic [W-1:0]   inner_q, inner_d;
    logic [W-1:0]   x_q, x_d;
    logic [W-1:0]   y_q, y_d;
    logic [2*W-1:0] cnt_q, cnt_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           xfer;
    logic           y_last;
    logic           x_last;

    always_comb begin
        state_d = state_q;
        outer_d = outer_q;
        inner_d = inner_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        xfer    = valid_q & act_ready;
        y_last  = (y_q == inner_q - IDX_ONE);
        x_last  = (x_q == outer_q - IDX_ONE);

        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    outer_d = outer_n;
                    inner_d = inner_n;
                    x_d     = '0;
                    y_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    // A zero trip count completes immediately without issuing anything
                    if ((outer_n != '0) && (inner_n != '0)) begin
                        state_d = S_RUN;
                        valid_d = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (xfer) begin
                    cnt_d = cnt_q + CNT_ONE;
                    // Final iteration leaves indices at (outer-1, inner-1)
                    if (!(x_last && y_last)) begin
                        if (y_last) begin
                            y_d = '0;
                            x_d = x_q + IDX_ONE;
                        end else begin
                            y_d = y_q + IDX_ONE;
                        end
                    end
                end
                if (abort) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (xfer && x_last && y_last) begin
                    state_d = S_DONE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            outer_q <= '0;
            inner_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            outer_q <= outer_d;
            inner_q <= inner_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign act_valid = valid_q;
    assign x_idx     = x_q;
    assign y_idx     = y_q;
    assign act_cnt   = cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire
